// File: rtl/motor_pwm_pkg.sv
// Shared types, default constants and the magnitude-clamp helper for motor_pwm_driver.
package motor_pwm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_e;

  localparam int DEF_PERIOD_CYCLES = 2500;
  localparam int DEF_CNT_W         = 12;
  localparam int DEF_DUTY_MAX      = 2400;
  localparam int DEF_DEADTIME      = 50;
  localparam int DEF_WDOG_PERIODS  = 8;

  // Unsigned magnitude of a two's-complement word, clamped to max_val.
  // 0 - 0x80000000 taken as unsigned is 2**31, so the most negative input cannot overflow.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int max_val);
    logic [31:0] mag;
    mag = v[31] ? (32'd0 - v) : v;
    return (mag > 32'(max_val)) ? 32'(max_val) : mag;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Wrapping modulo-PERIOD counter with synchronous clear and a cnt==0 pulse while counting.
module pwm_period_counter #(
  parameter int PERIOD = 4,
  parameter int W      = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_zero = i_en && (r_cnt == '0);

endmodule

// File: rtl/motor_pwm_driver.sv
// Single H-bridge channel PWM driver: signed PID word -> direction + clamped duty, double-buffered,
// with dead-time on reversal. Define MOTOR_PWM_WATCHDOG_EN to add the command-loss watchdog (wdog_trip).
module motor_pwm_driver
  import motor_pwm_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int DUTY_MAX      = DEF_DUTY_MAX,
  parameter int DEADTIME      = DEF_DEADTIME,
  parameter int WDOG_PERIODS  = DEF_WDOG_PERIODS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic signed [31:0] pid_result,
  input  logic               pid_valid,
  output logic               pwm_fwd,
  output logic               pwm_rev,
  output logic               period_start,
  output logic [CNT_W-1:0]   duty_active,
  output logic               dir_active
`ifdef MOTOR_PWM_WATCHDOG_EN
  ,
  output logic               wdog_trip
`endif
);

  if (PERIOD_CYCLES < 4 || (1 << CNT_W) < PERIOD_CYCLES || DUTY_MAX > PERIOD_CYCLES - 1 ||
      DEADTIME >= PERIOD_CYCLES || WDOG_PERIODS < 1) begin : g_bad_params
    $error("motor_pwm_driver: inconsistent parameters");
  end

  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] w_cnt;
  logic             w_run, w_load, w_cnt_clr;
  logic [CNT_W-1:0] r_sh_duty, r_duty_active, w_duty_eff;
  logic             r_sh_dir, r_dir_active, w_dir_eff;
  logic             w_flip, w_gate, w_on;
  logic             r_pwm_fwd, r_pwm_rev;

  assign w_run     = (r_state != IDLE);
  assign w_cnt_clr = !enable || !w_run;

  pwm_period_counter #(.PERIOD(PERIOD_CYCLES), .W(CNT_W)) u_period (
    .clk    (clk),
    .reset_n(reset_n),
    .i_en   (w_run),
    .i_clr  (w_cnt_clr),
    .o_cnt  (w_cnt),
    .o_zero (w_load)
  );

`ifdef MOTOR_PWM_WATCHDOG_EN
  localparam int               WD_W     = $clog2(WDOG_PERIODS + 1);
  localparam logic [WD_W-1:0]  WD_FULL  = WD_W'(WDOG_PERIODS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [WD_W-1:0] w_wd_cnt;
  logic            w_wrap, w_trip;

  assign w_wrap = w_run && enable && (w_cnt == CNT_LAST);
  assign w_trip = (w_wd_cnt == WD_FULL);

  // Counts silent periods; parks at WDOG_PERIODS until a fresh command or disable clears it.
  pwm_period_counter #(.PERIOD(WDOG_PERIODS + 1), .W(WD_W)) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .i_en   (w_wrap && !w_trip),
    .i_clr  (pid_valid || !enable),
    .o_cnt  (w_wd_cnt),
    .o_zero ()
  );

  assign wdog_trip = w_trip;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_duty <= '0;
      r_sh_dir  <= 1'b0;
    end else if (pid_valid) begin
      r_sh_duty <= CNT_W'(sat_abs(pid_result, DUTY_MAX));
      r_sh_dir  <= pid_result[31];
    end
`ifdef MOTOR_PWM_WATCHDOG_EN
    else if (w_trip) r_sh_duty <= '0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty_active <= '0;
      r_dir_active  <= 1'b0;
    end else if (w_load) begin
      r_duty_active <= r_sh_duty;
      r_dir_active  <= r_sh_dir;
    end
  end

  // The compare in the load cycle must already see the incoming command.
  assign w_duty_eff = w_load ? r_sh_duty : r_duty_active;
  assign w_dir_eff  = w_load ? r_sh_dir  : r_dir_active;
  assign w_flip     = w_load && (r_sh_dir != r_dir_active) && (r_sh_duty != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gate      = 1'b1;
    case (r_state)
      IDLE: if (enable) w_state_nxt = RUN;
      RUN: begin
        w_gate = w_flip && (DEADTIME != 0);
        if (w_flip && DEADTIME > 1) w_state_nxt = DEAD;
      end
      DEAD: if (w_cnt >= DT_LAST) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    if (!enable) w_state_nxt = IDLE;
  end

  assign w_on = !w_gate && enable && (w_cnt < w_duty_eff);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_fwd <= 1'b0;
      r_pwm_rev <= 1'b0;
    end else begin
      r_pwm_fwd <= w_on && !w_dir_eff;
      r_pwm_rev <= w_on &&  w_dir_eff;
    end
  end

  assign pwm_fwd      = r_pwm_fwd;
  assign pwm_rev      = r_pwm_rev;
  assign period_start = w_load;
  assign duty_active  = r_duty_active;
  assign dir_active   = r_dir_active;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed + randomized bench for motor_pwm_driver against a period-level behavioural model.
module tb_motor_pwm_driver;

  localparam int P = 100, CW = 8, DMAX = 95, DT = 4, WD = 3;

  logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b0, pid_valid = 1'b0;
  logic [31:0]   pid_result = 32'd0;
  logic          pwm_fwd, pwm_rev, period_start, dir_active;
  logic [CW-1:0] duty_active;
`ifdef MOTOR_PWM_WATCHDOG_EN
  logic          wdog_trip;
`endif

  int n_checks = 0, n_fail = 0;

  // model state: period position, run flag, shadow/applied command, dead window end, last outputs
  int m_cnt, m_duty, m_sh_duty, m_dead, m_wd;
  bit m_run, m_dir, m_sh_dir, m_fwd, m_rev;

  motor_pwm_driver #(.PERIOD_CYCLES(P), .CNT_W(CW), .DUTY_MAX(DMAX), .DEADTIME(DT), .WDOG_PERIODS(WD)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pid_result(pid_result), .pid_valid(pid_valid),
    .pwm_fwd(pwm_fwd), .pwm_rev(pwm_rev), .period_start(period_start),
    .duty_active(duty_active), .dir_active(dir_active)
`ifdef MOTOR_PWM_WATCHDOG_EN
    , .wdog_trip(wdog_trip)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_sat(input logic [31:0] v);
    longint s, a;
    s = longint'(signed'(v));
    a = (s < 0) ? -s : s;
    return (a > DMAX) ? DMAX : int'(a);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_sh_duty = 0; m_dead = 0; m_wd = 0;
    m_run = 0; m_dir = 0; m_sh_dir = 0; m_fwd = 0; m_rev = 0;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_step();
    bit load, d_dir, on, tripped;
    int d_duty, d_dead;
    load    = m_run && (m_cnt == 0);
    d_duty  = load ? m_sh_duty : m_duty;
    d_dir   = load ? m_sh_dir  : m_dir;
    d_dead  = load ? (((m_sh_dir != m_dir) && (m_sh_duty != 0)) ? DT : 0) : m_dead;
    on      = m_run && enable && (m_cnt >= d_dead) && (m_cnt < d_duty);
    tripped = 0;
`ifdef MOTOR_PWM_WATCHDOG_EN
    tripped = (m_wd == WD);
    if (pid_valid || !enable) m_wd = 0;
    else if (m_run && m_cnt == P - 1 && !tripped) m_wd++;
`endif
    m_fwd = on && !d_dir;
    m_rev = on && d_dir;
    m_duty = d_duty; m_dir = d_dir; m_dead = d_dead;
    if (pid_valid) begin
      m_sh_duty = m_sat(pid_result);
      m_sh_dir  = pid_result[31];
    end else if (tripped) m_sh_duty = 0;
    m_cnt = (enable && m_run) ? (m_cnt + 1) % P : 0;
    m_run = enable;
  endtask

  task automatic check_outputs();
    chk("pwm_fwd", 32'(pwm_fwd), 32'(m_fwd));
    chk("pwm_rev", 32'(pwm_rev), 32'(m_rev));
    chk("legs_exclusive", 32'(pwm_fwd & pwm_rev), 32'd0);
    chk("period_start", 32'(period_start), 32'(m_run && m_cnt == 0));
    chk("duty_active", 32'(duty_active), 32'(m_duty));
    chk("dir_active", 32'(dir_active), 32'(m_dir));
`ifdef MOTOR_PWM_WATCHDOG_EN
    chk("wdog_trip", 32'(wdog_trip), 32'(m_wd == WD));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    #1;
    check_outputs();
  endtask

  task automatic strobe(input logic [31:0] v);
    pid_valid = 1'b1; pid_result = v;
    cyc();
    pid_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int k = 0;
    while (!period_start && k < 2 * P) begin cyc(); k++; end
    chk("wait_period_start", 32'(period_start), 32'd1);
  endtask

  task automatic next_period();
    wait_ps();
    cyc();
  endtask

  // Count leg activity over one full period; index i is the cnt value of the compare.
  task automatic run_period(output int nf, output int nr, output int first_rev);
    nf = 0; nr = 0; first_rev = -1;
    wait_ps();
    for (int i = 0; i < P; i++) begin
      cyc();
      if (pwm_fwd) nf++;
      if (pwm_rev) begin
        if (first_rev < 0) first_rev = i;
        nr++;
      end
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 120));
      1:       return $urandom();
      2:       return 32'h8000_0000;
      3:       return 32'd0;
      4:       return 32'h7fff_ffff;
      default: return 32'd0 - 32'($urandom_range(1, 120));
    endcase
  endfunction

  initial begin
    int nf, nr, fr;
    model_reset();
    repeat (3) cyc();
    chk("rst_fwd", 32'(pwm_fwd), 32'd0);
    chk("rst_rev", 32'(pwm_rev), 32'd0);
    chk("rst_duty", 32'(duty_active), 32'd0);
    chk("rst_dir", 32'(dir_active), 32'd0);
    chk("rst_period_start", 32'(period_start), 32'd0);
    reset_n = 1'b1;
    repeat (2) cyc();

    // basic duty
    enable = 1'b1;
    strobe(32'd30);
    run_period(nf, nr, fr);
    chk("basic_fwd_cycles", 32'(nf), 32'd30);
    chk("basic_rev_cycles", 32'(nr), 32'd0);
    chk("basic_duty", 32'(duty_active), 32'd30);

    // saturation
    strobe(32'd1000);
    next_period();
    chk("sat_pos_duty", 32'(duty_active), 32'd95);
    chk("sat_pos_dir", 32'(dir_active), 32'd0);
    strobe(32'h8000_0000);
    next_period();
    chk("sat_min_duty", 32'(duty_active), 32'd95);
    chk("sat_min_dir", 32'(dir_active), 32'd1);

    // reversal dead-time
    strobe(32'd50);
    next_period();
    chk("rev_pre_dir", 32'(dir_active), 32'd0);
    strobe(32'hFFFF_FFCE);
    run_period(nf, nr, fr);
    chk("rev_fwd_cycles", 32'(nf), 32'd0);
    chk("rev_rev_cycles", 32'(nr), 32'd46);
    chk("rev_first_high", 32'(fr), 32'd4);

    // strobe coincident with the load
    wait_ps();
    pid_valid = 1'b1; pid_result = 32'd70;
    cyc();
    pid_valid = 1'b0;
    chk("coinc_old_duty", 32'(duty_active), 32'd50);
    chk("coinc_old_dir", 32'(dir_active), 32'd1);
    next_period();
    chk("coinc_new_duty", 32'(duty_active), 32'd70);
    chk("coinc_new_dir", 32'(dir_active), 32'd0);

    // enable drop mid-period, then resume on retained shadow
    wait_ps();
    repeat (20) cyc();
    chk("drop_pre_fwd", 32'(pwm_fwd), 32'd1);
    enable = 1'b0;
    cyc();
    chk("drop_fwd", 32'(pwm_fwd), 32'd0);
    chk("drop_rev", 32'(pwm_rev), 32'd0);
    chk("drop_period_start", 32'(period_start), 32'd0);
    repeat (5) cyc();
    enable = 1'b1;
    cyc();
    chk("reen_period_start", 32'(period_start), 32'd1);
    run_period(nf, nr, fr);
    chk("reen_fwd_cycles", 32'(nf), 32'd70);
    chk("reen_duty", 32'(duty_active), 32'd70);

`ifdef MOTOR_PWM_WATCHDOG_EN
    strobe(32'd40);
    for (int k = 0; k < 6 * P && !wdog_trip; k++) cyc();
    chk("wd_trip_set", 32'(wdog_trip), 32'd1);
    next_period();
    chk("wd_duty_zero", 32'(duty_active), 32'd0);
    strobe(32'd40);
    chk("wd_trip_clear", 32'(wdog_trip), 32'd0);
    next_period();
    chk("wd_duty_restored", 32'(duty_active), 32'd40);
`endif

    // randomized commands and enable drops
    for (int i = 0; i < 3000; i++) begin
      pid_valid = ($urandom_range(0, 19) == 0);
      if (pid_valid) pid_result = rand_val();
      if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      cyc();
    end
    pid_valid = 1'b0;

    // asynchronous reset while a leg is high
    enable = 1'b1;
    strobe(32'd60);
    next_period();
    repeat (10) cyc();
    chk("areset_pre_fwd", 32'(pwm_fwd), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_fwd", 32'(pwm_fwd), 32'd0);
    chk("areset_rev", 32'(pwm_rev), 32'd0);
    chk("areset_duty", 32'(duty_active), 32'd0);
    chk("areset_dir", 32'(dir_active), 32'd0);
    chk("areset_period_start", 32'(period_start), 32'd0);
    model_reset();
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (5) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
